mask_blob_stats: RTL and testbench

- Downstream consumer of the HSV threshold stage's binary row stream: 640-bit mask row, row address, write strobe, frame-done.
- Captures each written row and scans it serially, 32 bits per cycle.
- Accumulates per-frame blob statistics: pixel count, bounding box, coordinate sums.
- Publishes registered results once per frame for the tracking/overlay logic.

---
 rtl/mask_blob_stats_pkg.sv | 37 +++
 rtl/mask_chunk_reduce.sv | 34 +++
 rtl/mask_blob_stats.sv | 239 +++++++++++++++++++++++
 tb/tb_mask_blob_stats.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_blob_stats_pkg.sv
// Shared constants, typed limits and state encoding for the mask blob statistics block.
// BLOB_CENTROID_EN adds the DIV state used by the centroid divider.
package mask_blob_stats_pkg;

  localparam int ROW_W  = 640;
  localparam int ROW_N  = 480;
  localparam int CHUNK  = 32;
  localparam int NCHUNK = ROW_W / CHUNK;

  localparam int CNT_W = 19;
  localparam int SUM_W = 28;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  localparam int K_W    = 5;
  localparam int CH_LG  = 5;
  localparam int POP_W  = 6;
  localparam int ISUM_W = 15;
  localparam int RPOP_W = 10;
  localparam int RSX_W  = 19;
  localparam int DSTP_W = 6;

  localparam logic [X_W-1:0] X_LAST = X_W'(ROW_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROW_N - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ROWACC,
    PUBLISH
`ifdef BLOB_CENTROID_EN
    , DIV
`endif
  } state_t;

endpackage

// File: rtl/mask_chunk_reduce.sv
// Combinational reduction of one 32-bit mask chunk: popcount, column-index sum,
// first/last set column and any-hit, with columns offset by the chunk base.
module mask_chunk_reduce
  import mask_blob_stats_pkg::*;
(
  input  logic [CHUNK-1:0]  chunk,
  input  logic [X_W-1:0]    base,
  output logic [POP_W-1:0]  pop,
  output logic [ISUM_W-1:0] idx_sum,
  output logic [X_W-1:0]    first,
  output logic [X_W-1:0]    last,
  output logic              any
);

  always_comb begin
    pop     = '0;
    idx_sum = '0;
    first   = base;
    last    = base;
    any     = |chunk;
    // Descending pass leaves the lowest set column in first.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) first = base + X_W'(i);
    end
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        pop     = pop + POP_W'(1);
        idx_sum = idx_sum + ISUM_W'(base) + ISUM_W'(i);
        last    = base + X_W'(i);
      end
    end
  end

endmodule

// File: rtl/mask_blob_stats.sv
// Per-frame blob statistics over a serially scanned binary mask row stream.
// Optional feature macro: BLOB_CENTROID_EN (serial centroid divider, cent_x/cent_y).
module mask_blob_stats
  import mask_blob_stats_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_data,
  input  logic [Y_W-1:0]    row_data_addr,
  input  logic              wea,
  input  logic              frame_done_in,
  output logic [CNT_W-1:0]  pix_count,
  output logic [X_W-1:0]    x_min,
  output logic [X_W-1:0]    x_max,
  output logic [Y_W-1:0]    y_min,
  output logic [Y_W-1:0]    y_max,
  output logic [SUM_W-1:0]  sum_x,
  output logic [SUM_W-1:0]  sum_y,
`ifdef BLOB_CENTROID_EN
  output logic [X_W-1:0]    cent_x,
  output logic [Y_W-1:0]    cent_y,
`endif
  output logic              bbox_valid,
  output logic              result_valid,
  output logic              overrun,
  output logic              busy
);

  state_t state, state_nxt;

  logic [ROW_W-1:0]  row_buf;
  logic [Y_W-1:0]    row_addr;
  logic [K_W-1:0]    k;
  logic [RPOP_W-1:0] row_pop;
  logic [RSX_W-1:0]  row_sx;
  logic [X_W-1:0]    row_first, row_last;
  logic              row_hit;

  logic [CNT_W-1:0]  acc_cnt;
  logic [SUM_W-1:0]  acc_sx, acc_sy;
  logic [X_W-1:0]    acc_xmin, acc_xmax;
  logic [Y_W-1:0]    acc_ymin, acc_ymax;

  logic              frame_done_r, pend, frame_edge;

  logic [X_W-1:0]    base;
  logic [POP_W-1:0]  c_pop;
  logic [ISUM_W-1:0] c_isum;
  logic [X_W-1:0]    c_first, c_last;
  logic              c_any;

  assign frame_edge = frame_done_in & ~frame_done_r;
  assign base       = {k, {CH_LG{1'b0}}};
  assign busy       = (state != IDLE);

  mask_chunk_reduce u_reduce (
    .chunk   (row_buf[base +: CHUNK]),
    .base    (base),
    .pop     (c_pop),
    .idx_sum (c_isum),
    .first   (c_first),
    .last    (c_last),
    .any     (c_any)
  );

`ifdef BLOB_CENTROID_EN
  logic [DSTP_W-1:0] div_step;
  logic [SUM_W-1:0]  div_dvd;
  logic [CNT_W-1:0]  div_rem;
  logic [X_W-1:0]    div_quot;
  logic [CNT_W:0]    rem_sh;
  logic              q_bit;
  logic [CNT_W-1:0]  rem_nxt;
  logic [X_W-1:0]    quot_nxt;

  // One restoring step; the quotient never exceeds ROW_W-1 so 10 bits suffice.
  always_comb begin
    rem_sh   = {div_rem, div_dvd[SUM_W-1]};
    q_bit    = (rem_sh >= {1'b0, pix_count});
    rem_nxt  = q_bit ? CNT_W'(rem_sh - {1'b0, pix_count}) : rem_sh[CNT_W-1:0];
    quot_nxt = {div_quot[X_W-2:0], q_bit};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wea) state_nxt = SCAN;
               else if (frame_edge) state_nxt = PUBLISH;
      SCAN:    if (k == K_LAST) state_nxt = ROWACC;
      ROWACC:  state_nxt = (pend || frame_edge) ? PUBLISH : IDLE;
`ifdef BLOB_CENTROID_EN
      PUBLISH: state_nxt = (acc_cnt != '0) ? DIV : IDLE;
      DIV:     if (div_step == DSTP_W'(2 * SUM_W - 1)) state_nxt = IDLE;
`else
      PUBLISH: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_buf      <= '0;
      row_addr     <= '0;
      k            <= '0;
      row_pop      <= '0;
      row_sx       <= '0;
      row_first    <= '0;
      row_last     <= '0;
      row_hit      <= 1'b0;
      acc_cnt      <= '0;
      acc_sx       <= '0;
      acc_sy       <= '0;
      acc_xmin     <= X_LAST;
      acc_xmax     <= '0;
      acc_ymin     <= Y_LAST;
      acc_ymax     <= '0;
      frame_done_r <= 1'b0;
      pend         <= 1'b0;
      pix_count    <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      bbox_valid   <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef BLOB_CENTROID_EN
      cent_x       <= '0;
      cent_y       <= '0;
      div_step     <= '0;
      div_dvd      <= '0;
      div_rem      <= '0;
      div_quot     <= '0;
`endif
    end else begin
      frame_done_r <= frame_done_in;
      result_valid <= 1'b0;
      if (wea && state != IDLE) overrun <= 1'b1;
      if (frame_edge && (state == SCAN || state == ROWACC || (state == IDLE && wea)))
        pend <= 1'b1;

      case (state)
        IDLE: begin
          if (wea) begin
            row_buf  <= row_data;
            row_addr <= row_data_addr;
            k        <= '0;
          end
        end
        SCAN: begin
          row_pop <= row_pop + RPOP_W'(c_pop);
          row_sx  <= row_sx + RSX_W'(c_isum);
          if (c_any) begin
            if (!row_hit) row_first <= c_first;
            row_last <= c_last;
            row_hit  <= 1'b1;
          end
          k <= k + K_W'(1);
        end
        ROWACC: begin
          // Rows addressed beyond the frame are scanned but never counted.
          if (row_pop != '0 && row_addr <= Y_LAST) begin
            acc_cnt  <= acc_cnt + CNT_W'(row_pop);
            acc_sx   <= acc_sx + SUM_W'(row_sx);
            acc_sy   <= acc_sy + SUM_W'(row_pop) * SUM_W'(row_addr);
            acc_xmin <= (row_first < acc_xmin) ? row_first : acc_xmin;
            acc_xmax <= (row_last > acc_xmax) ? row_last : acc_xmax;
            acc_ymin <= (row_addr < acc_ymin) ? row_addr : acc_ymin;
            acc_ymax <= (row_addr > acc_ymax) ? row_addr : acc_ymax;
          end
          k         <= '0;
          row_pop   <= '0;
          row_sx    <= '0;
          row_first <= '0;
          row_last  <= '0;
          row_hit   <= 1'b0;
        end
        PUBLISH: begin
          pix_count  <= acc_cnt;
          sum_x      <= acc_sx;
          sum_y      <= acc_sy;
          bbox_valid <= (acc_cnt != '0);
          x_min      <= (acc_cnt != '0) ? acc_xmin : '0;
          x_max      <= (acc_cnt != '0) ? acc_xmax : '0;
          y_min      <= (acc_cnt != '0) ? acc_ymin : '0;
          y_max      <= (acc_cnt != '0) ? acc_ymax : '0;
          acc_cnt    <= '0;
          acc_sx     <= '0;
          acc_sy     <= '0;
          acc_xmin   <= X_LAST;
          acc_xmax   <= '0;
          acc_ymin   <= Y_LAST;
          acc_ymax   <= '0;
          pend       <= 1'b0;
`ifdef BLOB_CENTROID_EN
          result_valid <= (acc_cnt == '0);
          cent_x       <= '0;
          cent_y       <= '0;
          div_step     <= '0;
          div_dvd      <= acc_sx;
          div_rem      <= '0;
          div_quot     <= '0;
`else
          result_valid <= 1'b1;
`endif
        end
`ifdef BLOB_CENTROID_EN
        DIV: begin
          div_step <= div_step + DSTP_W'(1);
          if (div_step == DSTP_W'(SUM_W - 1)) begin
            cent_x   <= quot_nxt;
            div_dvd  <= sum_y;
            div_rem  <= '0;
            div_quot <= '0;
          end else if (div_step == DSTP_W'(2 * SUM_W - 1)) begin
            cent_y       <= quot_nxt[Y_W-1:0];
            result_valid <= 1'b1;
          end else begin
            div_dvd  <= {div_dvd[SUM_W-2:0], 1'b0};
            div_rem  <= rem_nxt;
            div_quot <= quot_nxt;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_blob_stats.sv
// Randomized self-checking bench for mask_blob_stats against a per-pixel frame model.
// Build with BLOB_CENTROID_EN defined to also check the centroid outputs and divider latency.
module tb_mask_blob_stats;

  logic         clk, rst;
  logic [639:0] row_data;
  logic [8:0]   row_data_addr;
  logic         wea, frame_done_in;
  logic [18:0]  pix_count;
  logic [9:0]   x_min, x_max;
  logic [8:0]   y_min, y_max;
  logic [27:0]  sum_x, sum_y;
  logic         bbox_valid, result_valid, overrun, busy;
`ifdef BLOB_CENTROID_EN
  logic [9:0]   cent_x;
  logic [8:0]   cent_y;
  localparam int EXTRA = 56;
`else
  localparam int EXTRA = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  longint m_cnt, m_sx, m_sy;
  int     m_xmin, m_xmax, m_ymin, m_ymax;

  mask_blob_stats dut (
    .clk           (clk),
    .rst           (rst),
    .row_data      (row_data),
    .row_data_addr (row_data_addr),
    .wea           (wea),
    .frame_done_in (frame_done_in),
    .pix_count     (pix_count),
    .x_min         (x_min),
    .x_max         (x_max),
    .y_min         (y_min),
    .y_max         (y_max),
    .sum_x         (sum_x),
    .sum_y         (sum_y),
`ifdef BLOB_CENTROID_EN
    .cent_x        (cent_x),
    .cent_y        (cent_y),
`endif
    .bbox_valid    (bbox_valid),
    .result_valid  (result_valid),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 639; m_xmax = 0; m_ymin = 479; m_ymax = 0;
  endtask

  task automatic m_row(input int addr, input logic [639:0] d);
    if (addr < 480) begin
      for (int c = 0; c < 640; c++) begin
        if (d[c]) begin
          m_cnt++;
          m_sx += c;
          m_sy += addr;
          if (c < m_xmin) m_xmin = c;
          if (c > m_xmax) m_xmax = c;
          if (addr < m_ymin) m_ymin = addr;
          if (addr > m_ymax) m_ymax = addr;
        end
      end
    end
  endtask

  function automatic logic [639:0] rand_row(input int mode);
    logic [639:0] d;
    int lo, hi;
    d = '0;
    if (mode == 4) begin
      lo = $urandom_range(0, 639);
      hi = $urandom_range(lo, 639);
      for (int c = lo; c <= hi; c++) d[c] = 1'b1;
    end else begin
      for (int w = 0; w < 20; w++) begin
        case (mode)
          0: d[w*32 +: 32] = 32'h0;
          1: d[w*32 +: 32] = $urandom & $urandom & $urandom;
          2: d[w*32 +: 32] = $urandom | $urandom;
          default: d[w*32 +: 32] = $urandom;
        endcase
      end
    end
    return d;
  endfunction

  task automatic send_row(input int addr, input logic [639:0] d, input int gap);
    @(posedge clk); #1;
    row_data = d; row_data_addr = 9'(addr); wea = 1'b1;
    m_row(addr, d);
    @(posedge clk); #1;
    wea = 1'b0;
    repeat (21 + gap) @(posedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".cnt"},  64'(pix_count), 64'(m_cnt));
    check({tag, ".sx"},   64'(sum_x), 64'(m_sx));
    check({tag, ".sy"},   64'(sum_y), 64'(m_sy));
    check({tag, ".bbv"},  64'(bbox_valid), 64'(m_cnt != 0));
    check({tag, ".xmin"}, 64'(x_min), 64'(m_cnt != 0 ? m_xmin : 0));
    check({tag, ".xmax"}, 64'(x_max), 64'(m_cnt != 0 ? m_xmax : 0));
    check({tag, ".ymin"}, 64'(y_min), 64'(m_cnt != 0 ? m_ymin : 0));
    check({tag, ".ymax"}, 64'(y_max), 64'(m_cnt != 0 ? m_ymax : 0));
`ifdef BLOB_CENTROID_EN
    check({tag, ".cx"}, 64'(cent_x), 64'(m_cnt != 0 ? m_sx / m_cnt : 0));
    check({tag, ".cy"}, 64'(cent_y), 64'(m_cnt != 0 ? m_sy / m_cnt : 0));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cnt"},  64'(pix_count), 0);
    check({tag, ".sx"},   64'(sum_x), 0);
    check({tag, ".sy"},   64'(sum_y), 0);
    check({tag, ".bb"},   64'({x_min, x_max, y_min, y_max}), 0);
    check({tag, ".flag"}, 64'({bbox_valid, result_valid, overrun, busy}), 0);
`ifdef BLOB_CENTROID_EN
    check({tag, ".cent"}, 64'({cent_x, cent_y}), 0);
`endif
  endtask

  // Edge raised while idle; result_valid must appear exactly 2 (+divider) cycles later.
  task automatic close_frame(input string tag);
    int lat;
    int exp_lat;
    exp_lat = 2 + ((m_cnt != 0) ? EXTRA : 0);
    @(posedge clk); #1;
    frame_done_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      frame_done_in = 1'b0;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check_frame(tag);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 64'({result_valid, busy}), 0);
    m_clear();
  endtask

  initial begin
    int nrows;
    int lat;
    logic [639:0] d;

    rst = 1'b1; wea = 1'b0; frame_done_in = 1'b0;
    row_data = '0; row_data_addr = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 8; r++) send_row(r * 60, '0, $urandom_range(0, 3));
    close_frame("empty");

    d = '0; d[5] = 1'b1;
    send_row(100, d, 0);
    close_frame("single");

    d = '0;
    for (int c = 32; c <= 63; c++) d[c] = 1'b1;
    for (int r = 10; r <= 19; r++) send_row(r, d, 0);
    close_frame("rect");

    d = '1;
    for (int r = 0; r < 480; r++) send_row(r, d, 0);
    check("full.model_cnt", 64'(m_cnt), 64'd307200);
    close_frame("full");

    d = '1;
    send_row(500, d, 1);
    d = '0; d[639] = 1'b1; d[0] = 1'b1;
    send_row(479, d, 0);
    close_frame("oob");

    for (int f = 0; f < 6; f++) begin
      nrows = $urandom_range(1, 8);
      for (int r = 0; r < nrows; r++)
        send_row($urandom_range(0, 511), rand_row($urandom_range(0, 4)), $urandom_range(0, 4));
      close_frame("rand");
    end

    // Edge mid-scan takes the pending path; a second row during scan is dropped.
    send_row(7, rand_row(3), 0);
    @(posedge clk); #1;
    d = rand_row(3);
    row_data = d; row_data_addr = 9'd479; wea = 1'b1;
    m_row(479, d);
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      wea = 1'b0;
      if (i == 3) frame_done_in = 1'b1;
      if (i == 4) frame_done_in = 1'b0;
      if (i == 5) begin
        row_data = '1; row_data_addr = 9'd200; wea = 1'b1;
      end
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    check("pend.lat", 64'(lat), 64'(23 + EXTRA));
    check_frame("pend");
    check("pend.overrun", 64'(overrun), 1);
    m_clear();

    send_row(33, rand_row(2), 0);
    close_frame("sticky");
    check("sticky.overrun", 64'(overrun), 1);

    // Reset while chunk 7 is being scanned.
    send_row(50, rand_row(3), 0);
    @(posedge clk); #1;
    row_data = rand_row(3); row_data_addr = 9'd60; wea = 1'b1;
    @(posedge clk); #1;
    wea = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();

    send_row(222, rand_row(1), 2);
    close_frame("postrst");
    check("postrst.overrun", 64'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
